// File: rtl/xcorr_engine.sv
// Lag-k cross-correlation engine over two N-sample signed buffers.
// Define XCORR_CIRCULAR_EN for circular indexing (default: linear).
module xcorr_engine #(
   parameter int N  = 16,
   parameter int DW = 8,
   parameter int LW = $clog2(N),
   parameter int AW = 2*DW+LW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_a,
   input  logic signed [DW-1:0] in_b,
   input  logic                 start,
   input  logic [LW-1:0]        lag,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [AW-1:0] result
);

   typedef enum logic [1:0] {LOAD, IDLE, RUN, DONE} state_t;

   localparam logic [LW-1:0] WP_LAST  = LW'(N-1);
   localparam logic [LW:0]   CNT_LAST = (LW+1)'(N);

   state_t                state;
   logic signed [DW-1:0]  mem_a [N];
   logic signed [DW-1:0]  mem_b [N];
   logic [LW-1:0]         wp;
   logic [LW-1:0]         k;
   logic [LW:0]           cnt;
   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]  acc;

   logic [LW-1:0]          idx;
   logic [LW-1:0]          j;
   logic                   wrap;
   logic signed [2*DW-1:0] term;
   logic signed [AW-1:0]   prod_ext;
   logic                   we;
   logic [LW-1:0]          waddr;

   always_comb begin
      idx       = cnt[LW-1:0];
      {wrap, j} = {1'b0, idx} + {1'b0, k};
      term      = mem_a[idx] * mem_b[j];
`ifdef XCORR_CIRCULAR_EN
`else
      if (wrap) term = '0;
`endif
      prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
      we       = !reset && in_valid &&
                 (state == LOAD || (state == IDLE && !start));
      waddr    = (state == LOAD) ? wp : '0;
   end

   // Buffers are never cleared; a full reload follows every reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_a[waddr] <= in_a;
         mem_b[waddr] <= in_b;
      end
   end

   // RUN spans N+1 edges: products are registered one cycle ahead of the add.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD;
         wp        <= '0;
         k         <= '0;
         cnt       <= '0;
         prod      <= '0;
         acc       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  wp <= wp + 1'b1;
                  if (wp == WP_LAST) begin
                     state    <= IDLE;
                     in_ready <= 1'b0;
                  end
               end
            end
            IDLE: begin
               if (start) begin
                  k     <= lag;
                  cnt   <= '0;
                  acc   <= '0;
                  prod  <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else if (in_valid) begin
                  wp       <= LW'(1);
                  in_ready <= 1'b1;
                  state    <= LOAD;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               acc <= acc + prod_ext;
               if (cnt != CNT_LAST) prod <= term;
               if (cnt == CNT_LAST) begin
                  result    <= acc + prod_ext;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_xcorr_engine.sv
// Randomized self-checking bench for xcorr_engine against a
// behavioural correlation model (honours XCORR_CIRCULAR_EN).
module tb_xcorr_engine;

   localparam int N  = 16;
   localparam int DW = 8;
   localparam int LW = 4;
   localparam int AW = 20;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_a;
   logic signed [DW-1:0] in_b;
   logic                 start;
   logic [LW-1:0]        lag;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [AW-1:0] result;

   int n_tests = 0;
   int n_fail  = 0;
   int ma [N];
   int mb [N];
   longint last_res;

   xcorr_engine #(.N(N), .DW(DW), .LW(LW), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .start(start), .lag(lag), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got,
                        input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model(input int kk);
      longint s = 0;
      for (int i = 0; i < N; i++) begin
         int jj = i + kk;
`ifdef XCORR_CIRCULAR_EN
         jj = jj % N;
`else
         if (jj >= N) continue;
`endif
         s += longint'(ma[i] * mb[jj]);
      end
      return s;
   endfunction

   task automatic load(input bit from_idle, input bit gap,
                       input bit start_mid);
      for (int p = 0; p < N; p++) begin
         int w = 0;
         if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_a = DW'(ma[p]);
         in_b = DW'(mb[p]);
         in_valid = 1'b1;
         start = start_mid && (p == N/2);
         if (!(p == 0 && from_idle)) begin
            while (!in_ready && w < 20) begin
               @(negedge clk);
               w++;
            end
            if (w >= 20) check("load_timeout", w, 0);
         end
         @(negedge clk);
         start = 1'b0;
         if (p == N-2) check("rdy_before_last", in_ready, 1);
         if (start_mid && p == N/2) check("start_in_load", busy, 0);
      end
      in_valid = 1'b0;
      check("rdy_after_load", in_ready, 0);
      check("busy_after_load", busy, 0);
   endtask

   task automatic run(input int kk, input int hold, input bit with_valid);
      longint exp = model(kk);
      int cyc = 0;
      lag = LW'(kk);
      start = 1'b1;
      in_valid = with_valid;
      in_a = DW'($urandom);
      in_b = DW'($urandom);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      check("busy_run", busy, 1);
      check("rdy_run", in_ready, 0);
      while (!out_valid && cyc < 64) begin
         start = 1'($urandom);
         in_valid = 1'($urandom);
         lag = LW'($urandom);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      check("latency", cyc, N+1);
      check($sformatf("result_k%0d", kk), result, exp);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start = 1'($urandom);
         in_valid = 1'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_result", result, exp);
      end
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", out_valid, 0);
      check("post_hs_busy", busy, 0);
      check("post_hs_result", result, exp);
      last_res = exp;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      start = 1'b0;
      lag = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_rdy", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_result", result, 0);

      for (int i = 0; i < N; i++) begin ma[i] = 1; mb[i] = 1; end
      load(1'b0, 1'b1, 1'b1);
      run(0, 0, 1'b0);
      run(5, 10, 1'b0);

      for (int i = 0; i < N; i++) begin ma[i] = i; mb[i] = 1; end
      load(1'b1, 1'b0, 1'b0);
      run(15, 1, 1'b0);

      for (int i = 0; i < N; i++) begin ma[i] = -128; mb[i] = 127; end
      load(1'b1, 1'b1, 1'b0);
      run(0, 2, 1'b0);
      check("extreme_const", last_res, -260096);
      run(0, 0, 1'b1);

      lag = LW'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_result", result, 0);
      check("abort_rdy", in_ready, 1);
      check("abort_busy", busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_start_ign", busy, 0);

      for (int i = 0; i < N; i++) begin
         ma[i] = int'($signed(DW'($urandom)));
         mb[i] = int'($signed(DW'($urandom)));
      end
      load(1'b0, 1'b0, 1'b1);
      run(int'($urandom_range(0, N-1)), 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            ma[i] = int'($signed(DW'($urandom)));
            mb[i] = int'($signed(DW'($urandom)));
         end
         load(1'b1, 1'($urandom), 1'b0);
         run(int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)),
             1'($urandom));
         run(int'($urandom_range(0, N-1)), 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xcorr_engine.md
XCORR_ENGINE -- requirements
Module: xcorr_engine

Interface
REQ-001 Parameter N, default 16, meaning samples per signal buffer (power of two, >=4).
REQ-002 Parameter DW, default 8, meaning signed sample width.
REQ-003 Parameter LW, default $clog2(N), meaning lag/index width.
REQ-004 Parameter AW, default 2*DW+LW, meaning accumulator/result width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  sample pair present on in_a/in_b.
REQ-008 in_ready  output  1  engine accepts a sample pair this cycle.
REQ-009 in_a  input  DW  signed sample of signal A.
REQ-010 in_b  input  DW  signed sample of signal B.
REQ-011 start  input  1  request one correlation at lag.
REQ-012 lag  input  LW  lag k, sampled when start is accepted.
REQ-013 busy  output  1  high in RUN or DONE.
REQ-014 out_valid  output  1  result holds a finished correlation.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 result  output  AW  signed sum of products.

Function
REQ-017 States SHALL be LOAD, IDLE, RUN, DONE; reset enters LOAD.
REQ-018 LOAD: in_ready=1; each in_valid cycle writes in_a/in_b to A[wp]/B[wp], wp increments; write of wp=N-1 goes to IDLE, wp wraps to 0.
REQ-019 start in LOAD SHALL be ignored (no state change, no capture).
REQ-020 IDLE: in_ready=0; start=1 captures lag into k, clears accumulator and index i to 0, goes to RUN.
REQ-021 IDLE: in_valid=1 with start=0 SHALL return to LOAD and write that pair as A[0]/B[0] (reload); start has priority when both are high.
REQ-022 RUN: one MAC per cycle, acc += A[i]*B[j], i=0..N-1, exactly N cycles, then DONE.
REQ-023 Linear mode: j=i+k; term SHALL contribute 0 when i+k>=N (N-k non-zero terms).
REQ-024 Products SHALL be full 2*DW signed, sign-extended to AW; no saturation, no overflow possible at AW.
REQ-025 Latency: start accepted at edge t -> out_valid high from edge t+N+1.
REQ-026 DONE: out_valid=1, result stable; out_valid&out_ready returns to IDLE next cycle, buffers retained.
REQ-027 start, in_valid, and lag SHALL be ignored in RUN and DONE.
REQ-028 result SHALL hold last value after handshake until next RUN completes.

Reset
REQ-029 reset=1 at any edge, including mid-RUN/DONE, SHALL abort: state=LOAD, wp=0, i=0, acc=0, result=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-030 Sample buffers need not be cleared; a fresh LOAD of N pairs is required after reset.

Configuration
REQ-031 Macro XCORR_CIRCULAR_EN defined: j=(i+k) mod N; all N terms contribute (circular correlation).
REQ-032 Macro undefined: linear mode per REQ-023; latency identical in both builds.

Verification
REQ-033 N=16, A=B=all +1, lag=0 -> result=16 at t+17; lag=5 -> 11 (linear) / 16 (circular).
REQ-034 A=ramp 0..15, B=all +1, lag=15 -> result=0 (linear: A[0]*B[15]=0), 120 (circular).
REQ-035 A=all -128, B=all +127, lag=0, DW=8 -> result=-260096, no wrap.
REQ-036 out_ready held low 10 cycles in DONE -> out_valid and result stable; start pulses ignored; release -> IDLE.
REQ-037 reset asserted at RUN cycle 7 -> next cycle out_valid=0, result=0, in_ready=1, state LOAD; start ignored until 16 pairs reloaded.
REQ-038 in_valid gapped every other cycle during LOAD -> exactly 16 accepted pairs, then in_ready=0; start and in_valid same cycle in IDLE -> RUN taken.
